// File: rtl/cvxif_copro_responder.sv
// rtl/cvxif_copro_responder.sv - CV-X-IF coprocessor: ADD/XOR/EXC (ADD3 with CVXIF_COPRO_RS3_EN), in-order result queue with kill.
package cvxif_pkg;
   localparam int XLEN = 32;
   localparam int ID_W = 4;

   typedef struct packed {
      logic [31:0]           instr;
      logic [ID_W-1:0]       id;
      logic [2:0][XLEN-1:0]  rs;
      logic [2:0]            rs_valid;
   } x_issue_req_t;

   typedef struct packed {
      logic accept;
      logic writeback;
      logic dualwrite;
      logic dualread;
      logic loadstore;
      logic exc;
   } x_issue_resp_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            commit_kill;
   } x_commit_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [XLEN-1:0] addr;
      logic [1:0]      mode;
      logic            we;
      logic [1:0]      size;
      logic [XLEN-1:0] wdata;
      logic            last;
      logic            spec;
   } x_mem_req_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [XLEN-1:0] data;
      logic [4:0]      rd;
      logic            we;
      logic            exc;
      logic [5:0]      exccode;
   } x_result_t;

   typedef struct packed {
      logic         x_issue_valid;
      x_issue_req_t x_issue_req;
      logic         x_commit_valid;
      x_commit_t    x_commit;
      logic         x_result_ready;
   } cvxif_req_t;

   typedef struct packed {
      logic          x_issue_ready;
      x_issue_resp_t x_issue_resp;
      logic          x_mem_valid;
      x_mem_req_t    x_mem_req;
      logic          x_result_valid;
      x_result_t     x_result;
   } cvxif_resp_t;
endpackage

module cvxif_copro_responder #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  cvxif_pkg::cvxif_req_t  cvxif_req_i,
   output cvxif_pkg::cvxif_resp_t cvxif_resp_o
);
   import cvxif_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   x_result_t        mem_q [DEPTH];
   x_result_t        mem_d [DEPTH];
   logic [DEPTH-1:0] killed_q, killed_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   x_issue_req_t     ireq;
   logic [6:0]       opcode, funct7;
   logic [2:0]       funct3;
   logic [4:0]       rd;
   logic             is_custom, op_add, op_xor, op_exc, accept;
   logic             issue_ready, push, head_valid, head_killed, result_valid, pop, kill_en;
   logic [XLEN-1:0]  sum_ab;
   x_result_t        new_entry;
`ifdef CVXIF_COPRO_RS3_EN
   logic             op_add3;
`endif

   assign ireq   = cvxif_req_i.x_issue_req;
   assign opcode = ireq.instr[6:0];
   assign rd     = ireq.instr[11:7];
   assign funct3 = ireq.instr[14:12];
   assign funct7 = ireq.instr[31:25];
   assign sum_ab = ireq.rs[0] + ireq.rs[1];

   always_comb begin
      is_custom = (opcode == 7'b1111011) && (funct7 == 7'd0);
      op_add    = is_custom && (funct3 == 3'b000);
      op_xor    = is_custom && (funct3 == 3'b001);
      op_exc    = is_custom && (funct3 == 3'b011);
      accept    = ((op_add || op_xor) && (&ireq.rs_valid[1:0])) || (op_exc && ireq.rs_valid[0]);
`ifdef CVXIF_COPRO_RS3_EN
      op_add3   = is_custom && (funct3 == 3'b010);
      accept    = accept || (op_add3 && (&ireq.rs_valid));
`endif
      new_entry         = '0;
      new_entry.id      = ireq.id;
      new_entry.rd      = rd;
      if (op_exc) begin
         new_entry.exc     = 1'b1;
         new_entry.exccode = ireq.rs[0][5:0];
      end else begin
         new_entry.we      = (rd != 5'd0);
         if (op_xor) new_entry.data = ireq.rs[0] ^ ireq.rs[1];
`ifdef CVXIF_COPRO_RS3_EN
         else if (op_add3) new_entry.data = sum_ab + ireq.rs[2];
`endif
         else new_entry.data = sum_ab;
      end
   end

   // A killed head is never shown; it is popped regardless of result_ready.
   assign issue_ready  = (count_q != FULL_CNT);
   assign push         = cvxif_req_i.x_issue_valid && issue_ready && accept;
   assign head_valid   = (count_q != '0);
   assign head_killed  = killed_q[rd_ptr_q];
   assign result_valid = head_valid && !head_killed;
   assign pop          = head_valid && (head_killed || cvxif_req_i.x_result_ready);
   assign kill_en      = cvxif_req_i.x_commit_valid && cvxif_req_i.x_commit.commit_kill;

   always_comb begin
      mem_d    = mem_q;
      killed_d = killed_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Stale slots may get marked too; harmless since a push rewrites its flag.
      if (kill_en) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[i].id == cvxif_req_i.x_commit.id) killed_d[i] = 1'b1;
         end
      end
      if (push) begin
         mem_d[wr_ptr_q]    = new_entry;
         killed_d[wr_ptr_q] = kill_en && (cvxif_req_i.x_commit.id == ireq.id);
         wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         killed_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         killed_q <= killed_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      cvxif_resp_o                        = '0;
      cvxif_resp_o.x_issue_ready          = issue_ready;
      cvxif_resp_o.x_issue_resp.accept    = accept;
      cvxif_resp_o.x_issue_resp.writeback = accept && !op_exc;
      cvxif_resp_o.x_result_valid         = result_valid;
      cvxif_resp_o.x_result               = result_valid ? mem_q[rd_ptr_q] : '0;
   end

`ifdef CVXIF_COPRO_RS3_EN
   logic unused_bits;
   assign unused_bits = ^{ireq.instr[24:15]};
`else
   logic unused_bits;
   assign unused_bits = ^{ireq.instr[24:15], ireq.rs[2], ireq.rs_valid[2]};
`endif
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// tb/tb_cvxif_copro_responder.sv - directed self-checking bench for cvxif_copro_responder.
module tb_cvxif_copro_responder;
   import cvxif_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   cvxif_req_t  req;
   cvxif_resp_t resp;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   cvxif_copro_responder #(.DEPTH(4)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cvxif_req_i  (req),
      .cvxif_resp_o (resp)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_issue(input logic [3:0] id, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] rs0, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [2:0] rsv, input logic [6:0] opc, input logic [6:0] f7);
      req.x_issue_valid          = 1'b1;
      req.x_issue_req.instr      = {f7, 10'd0, f3, rd, opc};
      req.x_issue_req.id         = id;
      req.x_issue_req.rs[0]      = rs0;
      req.x_issue_req.rs[1]      = rs1;
      req.x_issue_req.rs[2]      = rs2;
      req.x_issue_req.rs_valid   = rsv;
   endtask

   localparam logic [6:0] OPC = 7'b1111011;

   initial begin
      req = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_issue_ready", resp.x_issue_ready, 1);
      check("rst_result_valid", resp.x_result_valid, 0);
      check("rst_result_fields", resp.x_result, 0);
      check("rst_mem_valid", {resp.x_mem_valid, resp.x_mem_req}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // ADD with wrap, result one cycle later
      req.x_result_ready = 1'b1;
      drive_issue(4'd3, 3'b000, 5'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 3'b011, OPC, 7'd0);
      #1;
      check("add_accept", resp.x_issue_resp.accept, 1);
      check("add_writeback", resp.x_issue_resp.writeback, 1);
      check("add_no_early_result", resp.x_result_valid, 0);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("add_result_valid", resp.x_result_valid, 1);
      check("add_result", {resp.x_result.id, resp.x_result.data, resp.x_result.rd, resp.x_result.we, resp.x_result.exc},
            {4'd3, 32'd1, 5'd5, 1'b1, 1'b0});
      tick();
      check("add_popped", resp.x_result_valid, 0);

      // Unsupported opcode, missing rs_valid, nonzero funct7
      drive_issue(4'd1, 3'b000, 5'd5, 32'd1, 32'd1, 32'd0, 3'b011, 7'b0110011, 7'd0);
      #1;
      check("badopc_accept", resp.x_issue_resp.accept, 0);
      check("badopc_writeback", resp.x_issue_resp.writeback, 0);
      drive_issue(4'd1, 3'b000, 5'd5, 32'd1, 32'd1, 32'd0, 3'b001, OPC, 7'd0);
      #1;
      check("rsvalid_accept", resp.x_issue_resp.accept, 0);
      drive_issue(4'd1, 3'b001, 5'd5, 32'd1, 32'd1, 32'd0, 3'b011, OPC, 7'd1);
      #1;
      check("funct7_accept", resp.x_issue_resp.accept, 0);
      drive_issue(4'd1, 3'b111, 5'd5, 32'd1, 32'd1, 32'd0, 3'b111, OPC, 7'd0);
      #1;
      check("funct3_accept", resp.x_issue_resp.accept, 0);
      tick();
      req.x_issue_valid = 1'b0;
      tick();
      check("rejected_no_result", resp.x_result_valid, 0);

      // XOR to rd=0: we must be 0
      drive_issue(4'd2, 3'b001, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 3'b011, OPC, 7'd0);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("xor_result", {resp.x_result_valid, resp.x_result.id, resp.x_result.data, resp.x_result.we},
            {1'b1, 4'd2, 32'h0000_0FF0, 1'b0});
      tick();

      // EXC
      drive_issue(4'd7, 3'b011, 5'd9, 32'd2, 32'd0, 32'd0, 3'b001, OPC, 7'd0);
      #1;
      check("exc_accept_wb", {resp.x_issue_resp.accept, resp.x_issue_resp.writeback}, 2'b10);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("exc_result", {resp.x_result_valid, resp.x_result.id, resp.x_result.exc, resp.x_result.exccode,
                           resp.x_result.we, resp.x_result.data},
            {1'b1, 4'd7, 1'b1, 6'd2, 1'b0, 32'd0});
      tick();

      // Fill the queue (pointers wrap here), then drain in order
      req.x_result_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_issue(4'(i), 3'b000, 5'(i + 1), 32'(i * 10), 32'd1, 32'd0, 3'b011, OPC, 7'd0);
         #1;
         check("fill_ready", resp.x_issue_ready, 1);
         tick();
      end
      req.x_issue_valid = 1'b0;
      #1;
      check("full_ready", resp.x_issue_ready, 0);
      check("full_head", {resp.x_result_valid, resp.x_result.id, resp.x_result.data}, {1'b1, 4'd0, 32'd1});
      req.x_result_ready = 1'b1;
      drive_issue(4'd8, 3'b000, 5'd1, 32'd5, 32'd5, 32'd0, 3'b011, OPC, 7'd0);
      #1;
      check("full_ready_with_pop", resp.x_issue_ready, 0);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("ready_after_pop", resp.x_issue_ready, 1);
      for (int k = 1; k < 4; k++) begin
         check("drain_order", {resp.x_result_valid, resp.x_result.id, resp.x_result.data},
               {1'b1, 4'(k), 32'(k * 10 + 1)});
         tick();
      end
      check("drained_no_id8", resp.x_result_valid, 0);

      // Kill with commit_kill=0 ignored, kill=1 drops id 4
      req.x_result_ready = 1'b0;
      drive_issue(4'd4, 3'b000, 5'd1, 32'd4, 32'd0, 32'd0, 3'b011, OPC, 7'd0);
      tick();
      drive_issue(4'd5, 3'b000, 5'd2, 32'd5, 32'd0, 32'd0, 3'b011, OPC, 7'd0);
      tick();
      req.x_issue_valid = 1'b0;
      req.x_commit_valid = 1'b1;
      req.x_commit.id = 4'd4;
      req.x_commit.commit_kill = 1'b0;
      tick();
      check("nokill_head", {resp.x_result_valid, resp.x_result.id}, {1'b1, 4'd4});
      req.x_commit.commit_kill = 1'b1;
      tick();
      req.x_commit_valid = 1'b0;
      req.x_result_ready = 1'b1;
      #1;
      check("killed_head_hidden", resp.x_result_valid, 0);
      tick();
      check("after_kill_head", {resp.x_result_valid, resp.x_result.id, resp.x_result.data}, {1'b1, 4'd5, 32'd5});
      tick();
      check("after_kill_empty", resp.x_result_valid, 0);

      // Kill arriving with the push
      drive_issue(4'd6, 3'b000, 5'd1, 32'd6, 32'd0, 32'd0, 3'b011, OPC, 7'd0);
      req.x_commit_valid = 1'b1;
      req.x_commit.id = 4'd6;
      req.x_commit.commit_kill = 1'b1;
      tick();
      req.x_issue_valid = 1'b0;
      req.x_commit_valid = 1'b0;
      #1;
      check("kill_on_push_hidden", resp.x_result_valid, 0);
      tick();
      check("kill_on_push_gone", {resp.x_result_valid, resp.x_issue_ready}, 2'b01);

      // ADD3
      drive_issue(4'd2, 3'b010, 5'd4, 32'd1, 32'd2, 32'd3, 3'b111, OPC, 7'd0);
      #1;
`ifdef CVXIF_COPRO_RS3_EN
      check("add3_accept", resp.x_issue_resp.accept, 1);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("add3_result", {resp.x_result_valid, resp.x_result.data}, {1'b1, 32'd6});
`else
      check("add3_accept", resp.x_issue_resp.accept, 0);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("add3_result", resp.x_result_valid, 0);
`endif
      tick();

      // Reset with two entries queued
      req.x_result_ready = 1'b0;
      drive_issue(4'd9, 3'b000, 5'd1, 32'd9, 32'd0, 32'd0, 3'b011, OPC, 7'd0);
      tick();
      drive_issue(4'd10, 3'b000, 5'd1, 32'd10, 32'd0, 32'd0, 3'b011, OPC, 7'd0);
      tick();
      req.x_issue_valid = 1'b0;
      #1;
      check("pre_reset_head", {resp.x_result_valid, resp.x_result.id}, {1'b1, 4'd9});
      rst_n = 1'b0;
      #1;
      check("midrst_result_valid", resp.x_result_valid, 0);
      check("midrst_issue_ready", resp.x_issue_ready, 1);
      check("midrst_fields", resp.x_result, 0);
      tick();
      rst_n = 1'b1;
      req.x_result_ready = 1'b1;
      tick();
      tick();
      check("postrst_no_result", resp.x_result_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
